// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold limit and a one-cycle dead gap on every hand-over.
// Latency: grant registered 1 cycle after req is sampled; all outputs are flops. Backpressure: level-sensitive req, owner keeps grant until release or contended HOLD_MAX expiry.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] gnt_sel,
    output logic       gnt_en,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [1:0] sel_nxt;
    logic       en_nxt;
    logic       pre_nxt;
    logic [3:0] rot;
    logic [1:0] winner;
    logic       others;

    // Rotate req so bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        rot = 4'({req, req} >> ptr);
        if (rot[0])      winner = ptr;
        else if (rot[1]) winner = ptr + 2'd1;
        else if (rot[2]) winner = ptr + 2'd2;
        else             winner = ptr + 2'd3;
        others = |(req & ~(4'b0001 << gnt_sel));
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        sel_nxt   = gnt_sel;
        en_nxt    = 1'b0;
        pre_nxt   = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                    en_nxt    = 1'b1;
                    hold_nxt  = 8'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                // Release is checked first so it wins over a coincident expiry.
                if (!req[gnt_sel]) begin
                    state_nxt = GAP;
                    ptr_nxt   = gnt_sel + 2'd1;
                end else if (others && hold_cnt == HOLD_LAST) begin
                    state_nxt = GAP;
                    ptr_nxt   = gnt_sel + 2'd1;
                    pre_nxt   = 1'b1;
                end else begin
                    en_nxt = 1'b1;
                    if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            gnt_sel  <= 2'd0;
            gnt_en   <= 1'b0;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt_sel  <= sel_nxt;
            gnt_en   <= en_nxt;
            gnt      <= en_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
            busy     <= (state_nxt == GRANT);
            preempt  <= pre_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: expected grants queued at drive time, popped and checked after each edge.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] gnt_sel, gnt_sel1;
    logic       gnt_en, gnt_en1;
    logic [3:0] gnt, gnt1;
    logic       busy, busy1;
    logic       preempt, preempt1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] g;
        logic       p;
        logic [3:0] g1;
        logic       p1;
        bit         c1;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] last_sel  = 2'd0;
    logic [1:0] last_sel1 = 2'd0;

    rr_arbiter4 #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_sel(gnt_sel), .gnt_en(gnt_en), .gnt(gnt), .busy(busy), .preempt(preempt)
    );

    rr_arbiter4 #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_sel(gnt_sel1), .gnt_en(gnt_en1), .gnt(gnt1), .busy(busy1), .preempt(preempt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive req, queue expectation for the next edge, then compare after that edge.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic ep,
                        input bit c1, input logic [3:0] eg1, input logic ep1, input string tag);
        exp_t e;
        req = r;
        e.g = eg; e.p = ep; e.g1 = eg1; e.p1 = ep1; e.c1 = c1; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.g != 4'b0000) last_sel = enc(e.g);
        check({e.tag, ".gnt"},     {4'h0, gnt},            {4'h0, e.g});
        check({e.tag, ".gnt_en"},  {7'h0, gnt_en},         {7'h0, |e.g});
        check({e.tag, ".busy"},    {7'h0, busy},           {7'h0, |e.g});
        check({e.tag, ".preempt"}, {7'h0, preempt},        {7'h0, e.p});
        check({e.tag, ".gnt_sel"}, {6'h0, gnt_sel},        {6'h0, last_sel});
        if (e.c1) begin
            if (e.g1 != 4'b0000) last_sel1 = enc(e.g1);
            check({e.tag, ".h1.gnt"},     {4'h0, gnt1},     {4'h0, e.g1});
            check({e.tag, ".h1.preempt"}, {7'h0, preempt1}, {7'h0, e.p1});
            check({e.tag, ".h1.gnt_sel"}, {6'h0, gnt_sel1}, {6'h0, last_sel1});
        end
    endtask

    task automatic s(input logic [3:0] r, input logic [3:0] eg, input logic ep, input string tag);
        step(r, eg, ep, 1'b0, 4'b0000, 1'b0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #12;
        check("reset.gnt",     {4'h0, gnt},     8'h00);
        check("reset.gnt_en",  {7'h0, gnt_en},  8'h00);
        check("reset.busy",    {7'h0, busy},    8'h00);
        check("reset.preempt", {7'h0, preempt}, 8'h00);
        check("reset.gnt_sel", {6'h0, gnt_sel}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s(4'b0000, 4'b0000, 1'b0, "idle");
        // Single request for index 2, then release through GAP to IDLE.
        s(4'b0100, 4'b0100, 1'b0, "single2");
        s(4'b0000, 4'b0000, 1'b0, "single2.gap");
        s(4'b0000, 4'b0000, 1'b0, "single2.idle");

        // ptr is 3: owner 3 releases while 0 waits, pointer wraps to 0.
        s(4'b1000, 4'b1000, 1'b0, "own3");
        s(4'b1001, 4'b1000, 1'b0, "own3.contend");
        s(4'b0001, 4'b0000, 1'b0, "own3.release");
        s(4'b0001, 4'b0001, 1'b0, "wrap0");
        s(4'b0000, 4'b0000, 1'b0, "wrap0.gap");
        s(4'b0000, 4'b0000, 1'b0, "wrap0.idle");

        // Uncontended owner must never be preempted.
        for (int i = 0; i < 20; i++) s(4'b0010, 4'b0010, 1'b0, $sformatf("solo1.%0d", i));
        s(4'b0000, 4'b0000, 1'b0, "solo1.gap");
        s(4'b0000, 4'b0000, 1'b0, "solo1.idle");

        // ptr is 2: owner 1 releases exactly when its hold limit is reached.
        s(4'b0010, 4'b0010, 1'b0, "coinc.grant");
        s(4'b0110, 4'b0010, 1'b0, "coinc.h1");
        s(4'b0110, 4'b0010, 1'b0, "coinc.h2");
        s(4'b0110, 4'b0010, 1'b0, "coinc.h3");
        s(4'b0100, 4'b0000, 1'b0, "coinc.gap");
        s(4'b0100, 4'b0100, 1'b0, "coinc.next");

        // Asynchronous reset between edges while gnt=0100.
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.gnt",     {4'h0, gnt},     8'h00);
        check("areset.gnt_en",  {7'h0, gnt_en},  8'h00);
        check("areset.busy",    {7'h0, busy},    8'h00);
        check("areset.gnt_sel", {6'h0, gnt_sel}, 8'h00);
        check("areset.h1.gnt",  {4'h0, gnt1},    8'h00);
        last_sel  = 2'd0;
        last_sel1 = 2'd0;
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full contention: HOLD_MAX=4 rotates in 4-cycle bursts, HOLD_MAX=1 alternates grant/GAP.
        for (int k = 0; k < 21; k++) begin
            logic [3:0] eg, eg1;
            logic       ep, ep1;
            if (k % 5 < 4) begin eg = 4'b0001 << ((k / 5) % 4); ep = 1'b0; end
            else           begin eg = 4'b0000;                 ep = 1'b1; end
            if (k % 2 == 0) begin eg1 = 4'b0001 << ((k / 2) % 4); ep1 = 1'b0; end
            else            begin eg1 = 4'b0000;                 ep1 = 1'b1; end
            step(4'b1111, eg, ep, 1'b1, eg1, ep1, $sformatf("all.%0d", k));
        end
        s(4'b0000, 4'b0000, 1'b0, "all.release");
        s(4'b0000, 4'b0000, 1'b0, "all.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
